// File: rtl/mem.sv
// MEM stage: registers the EX/MEM bundle, aligns load data and forwards results to WB/ID.
// Optional misaligned-address detection is enabled by defining MEM_ADDR_EXCP_EN.
module mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [75:0] ex_to_mem_bus,
  input  logic [4:0]  ex_load_bus,
  input  logic [2:0]  ex_save_bus,
  input  logic [65:0] ex_hi_lo_bus,
  input  logic [31:0] data_sram_rdata,
  output logic [69:0] mem_to_wb_bus,
  output logic [37:0] mem_to_rf_bus,
  output logic [65:0] mem_hi_lo_bus,
  output logic        mem_excp,
  output logic [31:0] mem_badvaddr
);

  logic [75:0] bus_r;
  logic [4:0]  load_r;
  logic [2:0]  save_r;
  logic [65:0] hilo_r;
  logic [31:0] rdata_h;
  logic        rdata_v;

  logic [31:0] pc, addr, word, load_res, rf_wdata;
  logic        ram_en, sel_rf_res, rf_we, rf_we_eff, is_load;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;
  logic [1:0]  a;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign pc         = bus_r[75:44];
  assign ram_en     = bus_r[43];
  assign ram_wen    = bus_r[42:39];
  assign sel_rf_res = bus_r[38];
  assign rf_we      = bus_r[37];
  assign rf_waddr   = bus_r[36:32];
  assign addr       = bus_r[31:0];
  assign is_load    = ram_en && (ram_wen == 4'b0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_r   <= '0;
      load_r  <= '0;
      save_r  <= '0;
      hilo_r  <= '0;
      rdata_h <= '0;
      rdata_v <= 1'b0;
    end else if (stall[3] && !stall[4]) begin
      bus_r   <= '0;
      load_r  <= '0;
      save_r  <= '0;
      hilo_r  <= '0;
      rdata_v <= 1'b0;
    end else if (!stall[3]) begin
      bus_r   <= ex_to_mem_bus;
      load_r  <= ex_load_bus;
      save_r  <= ex_save_bus;
      hilo_r  <= ex_hi_lo_bus;
      rdata_v <= 1'b0;
    end else if (is_load && !rdata_v) begin
      // SRAM word is only valid on the first MEM cycle; keep it for the rest of the stall
      rdata_h <= data_sram_rdata;
      rdata_v <= 1'b1;
    end
  end

  assign word     = rdata_v ? rdata_h : data_sram_rdata;
  assign a        = addr[1:0];
  assign byte_sel = word[{a, 3'b000} +: 8];
  assign half_sel = a[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_res = '0;
    if      (load_r[4]) load_res = {{24{byte_sel[7]}}, byte_sel};
    else if (load_r[3]) load_res = {24'b0, byte_sel};
    else if (load_r[2]) load_res = {{16{half_sel[15]}}, half_sel};
    else if (load_r[1]) load_res = {16'b0, half_sel};
    else if (load_r[0]) load_res = word;
  end

  assign rf_wdata = sel_rf_res ? load_res : addr;

`ifdef MEM_ADDR_EXCP_EN
  logic misalign;
  assign misalign     = ((load_r[2] | load_r[1] | save_r[1]) & addr[0])
                      | ((load_r[0] | save_r[0]) & (addr[1:0] != 2'b00));
  assign mem_excp     = misalign;
  assign mem_badvaddr = misalign ? addr : 32'b0;
  assign rf_we_eff    = rf_we & ~misalign;
`else
  logic unused_save;
  assign unused_save  = ^save_r;
  assign mem_excp     = 1'b0;
  assign mem_badvaddr = 32'b0;
  assign rf_we_eff    = rf_we;
`endif

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

  assign mem_to_wb_bus = {pc, rf_we_eff, rf_waddr, rf_wdata};
  assign mem_to_rf_bus = {rf_we_eff, rf_waddr, rf_wdata};
  assign mem_hi_lo_bus = hilo_r;

endmodule

// File: tb/tb_mem.sv
// Random + directed scoreboard bench for mem; model tracks the instruction in MEM by opcode.
`timescale 1ns/1ps
module tb_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [75:0] ex_to_mem_bus;
  logic [4:0]  ex_load_bus;
  logic [2:0]  ex_save_bus;
  logic [65:0] ex_hi_lo_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;
  logic [65:0] mem_hi_lo_bus;
  logic        mem_excp;
  logic [31:0] mem_badvaddr;

  mem dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_to_mem_bus(ex_to_mem_bus),
    .ex_load_bus(ex_load_bus), .ex_save_bus(ex_save_bus), .ex_hi_lo_bus(ex_hi_lo_bus),
    .data_sram_rdata(data_sram_rdata), .mem_to_wb_bus(mem_to_wb_bus),
    .mem_to_rf_bus(mem_to_rf_bus), .mem_hi_lo_bus(mem_hi_lo_bus),
    .mem_excp(mem_excp), .mem_badvaddr(mem_badvaddr)
  );

  always #5 clk = ~clk;

  // op: 0 alu, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 sb, 7 sh, 8 sw
  typedef struct {
    int unsigned op;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] res;
    logic [3:0]  wen;
    logic [65:0] hl;
  } ins_t;

  typedef struct {
    logic [69:0] wb;
    logic [37:0] rf;
    logic [65:0] hl;
    logic        ex;
    logic [31:0] bv;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  ins_t bubble_ins = '{op: 0, pc: 0, we: 0, wa: 0, res: 0, wen: 0, hl: 0};
  ins_t c_ins, m_ins;
  bit          m_held;
  logic [31:0] m_hw;

  task automatic drive(input ins_t i);
    logic en, sel;
    en  = (i.op != 0);
    sel = (i.op >= 1 && i.op <= 5);
    ex_to_mem_bus = {i.pc, en, (i.op >= 6) ? i.wen : 4'b0, sel, i.we, i.wa, i.res};
    ex_load_bus   = sel ? 5'(1 << (5 - i.op)) : 5'b0;
    ex_save_bus   = (i.op >= 6) ? 3'(1 << (8 - i.op)) : 3'b0;
    ex_hi_lo_bus  = i.hl;
  endtask

  function automatic exp_t exp_now();
    exp_t e;
    logic [31:0] w, v, adr;
    int unsigned a, b, h;
    logic flt, we;
    adr = m_ins.res;
    w   = m_held ? m_hw : data_sram_rdata;
    a   = adr % 4;
    b   = (w >> (8 * a)) & 255;
    h   = (w >> (16 * (a / 2))) & 65535;
    case (m_ins.op)
      1: v = (b >= 128) ? b - 32'd256 : b;
      2: v = b;
      3: v = (h >= 32768) ? h - 32'd65536 : h;
      4: v = h;
      5: v = w;
      default: v = m_ins.res;
    endcase
    flt = 1'b0;
`ifdef MEM_ADDR_EXCP_EN
    flt = ((m_ins.op == 3 || m_ins.op == 4 || m_ins.op == 7) && (adr % 2 != 0)) ||
          ((m_ins.op == 5 || m_ins.op == 8) && a != 0);
`endif
    we   = m_ins.we && !flt;
    e.wb = {m_ins.pc, we, m_ins.wa, v};
    e.rf = {we, m_ins.wa, v};
    e.hl = m_ins.hl;
    e.ex = flt;
    e.bv = flt ? adr : 32'b0;
    return e;
  endfunction

  function automatic exp_t exp_zero();
    exp_t e;
    e.wb = '0; e.rf = '0; e.hl = '0; e.ex = 1'b0; e.bv = '0;
    return e;
  endfunction

  // Advance the model across the clock edge using the values still driven from the last cycle
  task automatic model_edge();
    if (rst) begin
      m_ins = bubble_ins; m_held = 0;
    end else if (stall[3] && !stall[4]) begin
      m_ins = bubble_ins; m_held = 0;
    end else if (!stall[3]) begin
      m_ins = c_ins; m_held = 0;
    end else if (m_ins.op >= 1 && m_ins.op <= 5 && !m_held) begin
      m_held = 1; m_hw = data_sram_rdata;
    end
  endtask

  task automatic step(input logic [1:0] st, input ins_t ins, input logic [31:0] rd);
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;
    stall = {1'($urandom), st, 3'($urandom)};
    c_ins = ins;
    drive(ins);
    data_sram_rdata = rd;
    q.push_back(exp_now());
  endtask

  function automatic ins_t rand_ins();
    ins_t i;
    i.op  = $urandom_range(0, 8);
    i.pc  = $urandom;
    i.wa  = 5'($urandom);
    i.res = $urandom;
    i.we  = (i.op == 0) ? 1'($urandom) : (i.op <= 5);
    i.wen = 4'(1 << $urandom_range(0, 3));
    i.hl  = {2'($urandom), 32'($urandom), 32'($urandom)};
    return i;
  endfunction

  function automatic ins_t mk(input int unsigned op, input logic [31:0] adr);
    ins_t i;
    i = rand_ins();
    i.op = op; i.res = adr; i.we = (op <= 5);
    return i;
  endfunction

  task automatic cmp_all(input string tag, input exp_t e);
    total += 5;
    if (mem_to_wb_bus !== e.wb) begin bad++; $display("FAIL %s wb got=%h want=%h", tag, mem_to_wb_bus, e.wb); end
    if (mem_to_rf_bus !== e.rf) begin bad++; $display("FAIL %s rf got=%h want=%h", tag, mem_to_rf_bus, e.rf); end
    if (mem_hi_lo_bus !== e.hl) begin bad++; $display("FAIL %s hilo got=%h want=%h", tag, mem_hi_lo_bus, e.hl); end
    if (mem_excp !== e.ex) begin bad++; $display("FAIL %s excp got=%b want=%b", tag, mem_excp, e.ex); end
    if (mem_badvaddr !== e.bv) begin bad++; $display("FAIL %s badv got=%h want=%h", tag, mem_badvaddr, e.bv); end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare against the oldest expectation
  always @(negedge clk) begin
    if (q.size() > 0) cmp_all("cycle", q.pop_front());
  end

  initial begin
    ins_t nop;
    rst = 1'b1; stall = '0; data_sram_rdata = '0;
    c_ins = bubble_ins; m_ins = bubble_ins; m_held = 0; m_hw = '0;
    drive(bubble_ins);
    nop = bubble_ins;
    #1 cmp_all("reset", exp_zero());
    #20;

    // lb 0x1003 / 0x80FFFF12 -> 0xFFFFFF80
    step(2'b00, mk(1, 32'h1003), 32'h0);
    step(2'b00, nop, 32'h80FF_FF12);
    // lhu / lh at 0x2002 on 0xBEEF1234
    step(2'b00, mk(4, 32'h2002), 32'h0);
    step(2'b00, mk(3, 32'h2002), 32'hBEEF_1234);
    step(2'b00, nop, 32'hBEEF_1234);
    // addu result squashed by a bubble
    step(2'b00, mk(0, 32'h7), 32'h0);
    step(2'b01, nop, 32'h0);
    step(2'b00, nop, 32'h0);
    // lw at misaligned 0x102
    step(2'b00, mk(5, 32'h102), 32'h0);
    step(2'b00, nop, 32'hCAFE_F00D);
    // lw held through a full stall while SRAM data moves on
    step(2'b00, mk(5, 32'h40), 32'h0);
    step(2'b11, nop, 32'h1111_1111);
    step(2'b11, nop, 32'h2222_2222);
    step(2'b11, nop, 32'h2222_2222);
    step(2'b11, nop, 32'h3333_3333);
    // mid-cycle reset while the load is held
    #1 rst = 1'b1;
    m_ins = bubble_ins; m_held = 0;
    #1 cmp_all("async_rst", exp_zero());
    q.delete();
    q.push_back(exp_zero());
    step(2'b00, nop, 32'h4444_4444);
    step(2'b00, nop, 32'h0);

    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      logic [1:0] st;
      r  = $urandom_range(0, 9);
      st = (r < 5) ? 2'b00 : (r < 7) ? 2'b11 : (r < 9) ? 2'b01 : 2'b10;
      step(st, rand_ins(), $urandom);
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
